// File: rtl/simt_pkg.sv
// Shared constants, FSM state type and helpers for the SIMT register file.
package simt_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_TIDX = 5'd4;
  localparam logic [4:0] REG_BIDX = 5'd5;
  localparam logic [4:0] REG_BDIM = 5'd6;
  localparam logic [4:0] REG_LID  = 5'd7;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  // True for addresses that never hit GPR storage (x0 and the x4..x7 specials)
  function automatic logic is_special(input logic [4:0] addr);
    return (addr == REG_ZERO) || ((addr >= REG_TIDX) && (addr <= REG_LID));
  endfunction

endpackage

// File: rtl/simt_regbank.sv
// One thread's GPR storage plus its predicate bit: one write port, one clear-row
// port, two asynchronous read ports.
module simt_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_en,
  input  logic [4:0]            clr_addr,
  input  logic                  pred_wr_en,
  input  logic                  pred_in,
  input  logic                  pred_clr,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  pred
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // GPR rows: clear has priority, though the top never issues both at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          regs <= '0;
    else if (clr_en)  regs[clr_addr] <= '0;
    else if (wr_en)   regs[wr_addr] <= wr_data;
  end

  // Predicate bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pred <= 1'b0;
    else if (pred_clr)   pred <= 1'b0;
    else if (pred_wr_en) pred <= pred_in;
  end

  assign rdata1 = regs[ra1];
  assign rdata2 = regs[ra2];

endmodule

// File: rtl/simt_regfile.sv
// Per-thread register file: one bank per hardware thread, read-only special
// registers, registered reads with write-first bypass, and a row-per-cycle clear
// sequenced by a small FSM on block launch.
module simt_regfile
  import simt_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int WARP_SIZE   = 4,
  localparam int TW         = $clog2(NUM_THREADS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  block_start,
  input  logic [DATA_WIDTH-1:0] block_idx_in,
  input  logic [DATA_WIDTH-1:0] block_dim_in,
  output logic                  busy,
  input  logic                  rd_en,
  input  logic [TW-1:0]         rd_thread,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [DATA_WIDTH-1:0] rd2_data,
  output logic                  pred_out,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [TW-1:0]         wr_thread,
  input  logic [4:0]            wr_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pred_wr_en,
  input  logic [TW-1:0]         pred_wr_thread,
  input  logic                  pred_in
);

  localparam logic [TW-1:0] LANE_MASK = TW'(WARP_SIZE - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(NUM_REGS - 1);

  rf_state_t             state;
  logic [4:0]            clr_cnt;
  logic [DATA_WIDTH-1:0] bidx, bdim;

  logic rd_ok, wr_ok, pred_ok, clr_en, pred_clr;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] bank_rd1, bank_rd2;
  logic [NUM_THREADS-1:0]                 bank_pred;
  logic [DATA_WIDTH-1:0] nxt1, nxt2;
  logic                  nxt_pred;

  // Launch wins over same-cycle writes; the clear window blocks all traffic
  assign rd_ok    = rd_en & ~busy;
  assign wr_ok    = wr_en & ~busy & ~block_start & ~is_special(wr_rd);
  assign pred_ok  = pred_wr_en & ~busy & ~block_start;
  assign clr_en   = (state == RF_CLEAR);
  assign pred_clr = clr_en & (clr_cnt == 5'd1);

  // Launch/clear sequencer; busy mirrors the next state so it is a clean flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RF_IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
      bidx    <= '0;
      bdim    <= '0;
    end else if (block_start) begin
      state   <= RF_CLEAR;
      clr_cnt <= 5'd1;
      busy    <= 1'b1;
      bidx    <= block_idx_in;
      bdim    <= block_dim_in;
    end else if (state == RF_CLEAR) begin
      if (clr_cnt == LAST_ROW) begin
        state <= RF_IDLE;
        busy  <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 5'd1;
      end
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_bank
    simt_regbank #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_ok && (wr_thread == TW'(t))),
      .wr_addr    (wr_rd),
      .wr_data    (wr_data),
      .clr_en     (clr_en),
      .clr_addr   (clr_cnt),
      .pred_wr_en (pred_ok && (pred_wr_thread == TW'(t))),
      .pred_in    (pred_in),
      .pred_clr   (pred_clr),
      .ra1        (rs1),
      .ra2        (rs2),
      .rdata1     (bank_rd1[t]),
      .rdata2     (bank_rd2[t]),
      .pred       (bank_pred[t])
    );
  end

  // Special-register decode; GPR path takes the same-cycle write when it matches
  function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [4:0] a,
                                                   input logic [DATA_WIDTH-1:0] gpr);
    logic byp;
    byp = wr_ok && (wr_thread == rd_thread) && (wr_rd == a);
    case (a)
      REG_ZERO: rd_sel = '0;
      REG_TIDX: rd_sel = DATA_WIDTH'(rd_thread);
      REG_BIDX: rd_sel = bidx;
      REG_BDIM: rd_sel = bdim;
      REG_LID:  rd_sel = DATA_WIDTH'(rd_thread & LANE_MASK);
      default:  rd_sel = byp ? wr_data : gpr;
    endcase
  endfunction

  // Next read values
  always_comb begin
    nxt1     = rd_sel(rs1, bank_rd1[rd_thread]);
    nxt2     = rd_sel(rs2, bank_rd2[rd_thread]);
    nxt_pred = (pred_ok && (pred_wr_thread == rd_thread)) ? pred_in : bank_pred[rd_thread];
  end

  // Output registers hold their value unless a read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_data <= '0;
      rd2_data <= '0;
      pred_out <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd1_data <= nxt1;
        rd2_data <= nxt2;
        pred_out <= nxt_pred;
      end
    end
  end

endmodule

// File: tb/tb_simt_regfile.sv
// Directed bench for simt_regfile: reset, write/read, specials, bypass, clear,
// launch priority, restart and reset during clear.
module tb_simt_regfile;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          block_start = 1'b0;
  logic [DW-1:0] block_idx_in = '0, block_dim_in = '0;
  logic          busy;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_thread = '0;
  logic [4:0]    rs1 = '0, rs2 = '0;
  logic [DW-1:0] rd1_data, rd2_data;
  logic          pred_out, rd_valid;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_thread = '0;
  logic [4:0]    wr_rd = '0;
  logic [DW-1:0] wr_data = '0;
  logic          pred_wr_en = 1'b0;
  logic [1:0]    pred_wr_thread = '0;
  logic          pred_in = 1'b0;

  int nvec = 0;
  int nerr = 0;

  simt_regfile #(.NUM_THREADS(4), .DATA_WIDTH(DW), .NUM_REGS(32), .WARP_SIZE(4)) dut (
    .clk(clk), .rst(rst), .block_start(block_start), .block_idx_in(block_idx_in),
    .block_dim_in(block_dim_in), .busy(busy), .rd_en(rd_en), .rd_thread(rd_thread),
    .rs1(rs1), .rs2(rs2), .rd1_data(rd1_data), .rd2_data(rd2_data), .pred_out(pred_out),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_thread(wr_thread), .wr_rd(wr_rd),
    .wr_data(wr_data), .pred_wr_en(pred_wr_en), .pred_wr_thread(pred_wr_thread),
    .pred_in(pred_in)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [1:0] t, input logic [4:0] r, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_thread = t; wr_rd = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [1:0] t, input logic [4:0] a, input logic [4:0] b);
    rd_en = 1'b1; rd_thread = t; rs1 = a; rs2 = b;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_start(input logic [DW-1:0] idx, input logic [DW-1:0] dim);
    block_start = 1'b1; block_idx_in = idx; block_dim_in = dim;
    tick();
    block_start = 1'b0;
  endtask

  // Counts busy samples until busy falls (bounded)
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %0b want 0", busy); end
    nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %0b want 0", rd_valid); end
    nvec++; if (rd1_data !== 0 || rd2_data !== 0 || pred_out !== 1'b0) begin
      nerr++; $display("FAIL rst_data got %h %h %b want 0 0 0", rd1_data, rd2_data, pred_out);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    do_rd(2'd2, 5'd9, 5'd0);
    nvec++; if (rd_valid !== 1'b1 || rd1_data !== 0) begin
      nerr++; $display("FAIL rst_read got v=%b %h want v=1 0", rd_valid, rd1_data);
    end
    tick();
    nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid_drop got %b want 0", rd_valid); end
  endtask

  task automatic test_write_read();
    do_wr(2'd1, 5'd9, 32'hDEADBEEF);
    do_rd(2'd1, 5'd9, 5'd0);
    nvec++; if (rd1_data !== 32'hDEADBEEF || rd2_data !== 0) begin
      nerr++; $display("FAIL wr_rd got %h %h want deadbeef 0", rd1_data, rd2_data);
    end
    do_rd(2'd0, 5'd9, 5'd9);
    nvec++; if (rd1_data !== 0 || rd2_data !== 0) begin
      nerr++; $display("FAIL wr_other_thread got %h %h want 0 0", rd1_data, rd2_data);
    end
  endtask

  task automatic test_specials();
    int n;
    do_start(32'd7, 32'd4);
    count_busy(n);
    nvec++; if (n != 31) begin nerr++; $display("FAIL spec_busy_len got %0d want 31", n); end
    do_rd(2'd3, 5'd4, 5'd5);
    nvec++; if (rd1_data !== 32'd3 || rd2_data !== 32'd7) begin
      nerr++; $display("FAIL spec_tidx_bidx got %0d %0d want 3 7", rd1_data, rd2_data);
    end
    do_rd(2'd3, 5'd6, 5'd7);
    nvec++; if (rd1_data !== 32'd4 || rd2_data !== 32'd3) begin
      nerr++; $display("FAIL spec_bdim_lid got %0d %0d want 4 3", rd1_data, rd2_data);
    end
    do_wr(2'd3, 5'd5, 32'h55);
    do_rd(2'd3, 5'd5, 5'd9);
    nvec++; if (rd1_data !== 32'd7) begin nerr++; $display("FAIL spec_wr_drop got %h want 7", rd1_data); end
    do_rd(2'd1, 5'd9, 5'd0);
    nvec++; if (rd1_data !== 0) begin nerr++; $display("FAIL spec_cleared got %h want 0", rd1_data); end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_thread = 2'd2; wr_rd = 5'd12; wr_data = 32'h1234;
    pred_wr_en = 1'b1; pred_wr_thread = 2'd2; pred_in = 1'b1;
    do_rd(2'd2, 5'd12, 5'd12);
    wr_en = 1'b0; pred_wr_en = 1'b0;
    nvec++; if (rd1_data !== 32'h1234 || rd2_data !== 32'h1234 || pred_out !== 1'b1) begin
      nerr++; $display("FAIL byp got %h %h %b want 1234 1234 1", rd1_data, rd2_data, pred_out);
    end
    do_rd(2'd2, 5'd12, 5'd0);
    nvec++; if (rd1_data !== 32'h1234 || pred_out !== 1'b1) begin
      nerr++; $display("FAIL byp_commit got %h %b want 1234 1", rd1_data, pred_out);
    end
    wr_en = 1'b1; wr_thread = 2'd2; wr_rd = 5'd0; wr_data = 32'hAA;
    do_rd(2'd2, 5'd0, 5'd12);
    wr_en = 1'b0;
    nvec++; if (rd1_data !== 0 || rd2_data !== 32'h1234) begin
      nerr++; $display("FAIL byp_x0 got %h %h want 0 1234", rd1_data, rd2_data);
    end
  endtask

  task automatic test_clear();
    int n;
    do_wr(2'd0, 5'd31, 32'hFF);
    do_rd(2'd0, 5'd31, 5'd0);
    nvec++; if (rd1_data !== 32'hFF) begin nerr++; $display("FAIL clr_pre got %h want ff", rd1_data); end
    do_start(32'd7, 32'd4);
    tick(); tick();
    wr_en = 1'b1; wr_thread = 2'd0; wr_rd = 5'd20; wr_data = 32'h77;
    do_rd(2'd0, 5'd20, 5'd20);
    wr_en = 1'b0;
    nvec++; if (rd_valid !== 1'b0 || rd1_data !== 32'hFF) begin
      nerr++; $display("FAIL clr_busy_rd got v=%b %h want v=0 ff", rd_valid, rd1_data);
    end
    count_busy(n);
    nvec++; if (n != 28) begin nerr++; $display("FAIL clr_busy_len got %0d want 28 remaining", n); end
    do_rd(2'd0, 5'd31, 5'd20);
    nvec++; if (rd1_data !== 0 || rd2_data !== 0) begin
      nerr++; $display("FAIL clr_after got %h %h want 0 0", rd1_data, rd2_data);
    end
    do_rd(2'd2, 5'd12, 5'd0);
    nvec++; if (rd1_data !== 0 || pred_out !== 1'b0) begin
      nerr++; $display("FAIL clr_pred got %h %b want 0 0", rd1_data, pred_out);
    end
  endtask

  task automatic test_start_priority();
    int n;
    do_wr(2'd1, 5'd10, 32'h42);
    wr_en = 1'b1; wr_thread = 2'd1; wr_rd = 5'd10; wr_data = 32'h99;
    pred_wr_en = 1'b1; pred_wr_thread = 2'd1; pred_in = 1'b1;
    rd_en = 1'b1; rd_thread = 2'd1; rs1 = 5'd10; rs2 = 5'd5;
    do_start(32'h11, 32'h22);
    wr_en = 1'b0; pred_wr_en = 1'b0; rd_en = 1'b0;
    nvec++; if (rd_valid !== 1'b1 || rd1_data !== 32'h42 || rd2_data !== 32'd7 || pred_out !== 1'b0) begin
      nerr++; $display("FAIL prio got v=%b %h %h %b want v=1 42 7 0", rd_valid, rd1_data, rd2_data, pred_out);
    end
    count_busy(n);
    do_rd(2'd1, 5'd5, 5'd6);
    nvec++; if (rd1_data !== 32'h11 || rd2_data !== 32'h22) begin
      nerr++; $display("FAIL prio_spec got %h %h want 11 22", rd1_data, rd2_data);
    end
  endtask

  task automatic test_restart();
    int n;
    do_start(32'd3, 32'd8);
    for (int k = 1; k < 10; k++) tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rs_busy10 got %b want 1", busy); end
    do_start(32'd9, 32'd2);
    count_busy(n);
    nvec++; if (n != 31) begin nerr++; $display("FAIL rs_busy_len got %0d want 31", n); end
    do_rd(2'd0, 5'd5, 5'd6);
    nvec++; if (rd1_data !== 32'd9 || rd2_data !== 32'd2) begin
      nerr++; $display("FAIL rs_spec got %0d %0d want 9 2", rd1_data, rd2_data);
    end
  endtask

  task automatic test_reset_midclear();
    do_start(32'h5A, 32'd4);
    for (int k = 1; k < 5; k++) tick();
    #2 rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mc_busy got %b want 0", busy); end
    #1 rst = 1'b0;
    tick();
    do_rd(2'd0, 5'd5, 5'd6);
    nvec++; if (rd_valid !== 1'b1 || rd1_data !== 0 || rd2_data !== 0) begin
      nerr++; $display("FAIL mc_read got v=%b %h %h want v=1 0 0", rd_valid, rd1_data, rd2_data);
    end
    tick();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mc_idle got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_specials();
    test_bypass();
    test_clear();
    test_start_priority();
    test_restart();
    test_reset_midclear();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
